sargantana_icache_inval_sequencer: RTL and testbench

Generates the invalidation and flush write traffic consumed by the icache replace unit's `inval_i` / `flush_ena_i` / valid-bit write path.
- Accepts single-line invalidations from upper cache levels through a valid/ready handshake and a small FIFO.
- Accepts whole-cache flush requests from the core.
- Sequences valid-bit clear writes, one set per cycle, and never collides with core reads or refills.
- Sits between the L2/coherence interface and the icache valid-bit RAM control.

---
 rtl/sargantana_icache_inval_sequencer.sv | 124 ++++++++++++
 tb/tb_sargantana_icache_inval_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sargantana_icache_inval_sequencer.sv
// Invalidation / flush write sequencer for the icache valid-bit RAM.
// Single-line invalidations queue in a small FIFO; whole-cache flushes walk
// every set. At most one valid-bit write issues per cycle, and only when the
// core is not using the arrays.
module sargantana_icache_inval_sequencer #(
  parameter int ICACHE_N_WAY     = 4,
  parameter int ICACHE_IDX_WIDTH = 6,
  parameter int INVAL_Q_DEPTH    = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_req_i,
  output logic                            flush_ack_o,
  input  logic                            inval_valid_i,
  output logic                            inval_ready_o,
  input  logic [ICACHE_IDX_WIDTH-1:0]     inval_idx_i,
  input  logic [$clog2(ICACHE_N_WAY)-1:0] inval_way_i,
  input  logic                            inval_all_i,
  input  logic                            core_busy_i,
  output logic                            seq_busy_o,
  output logic                            flush_ena_o,
  output logic                            inval_o,
  output logic                            we_valid_o,
  output logic [ICACHE_IDX_WIDTH-1:0]     addr_valid_o,
  output logic [ICACHE_N_WAY-1:0]         way_mask_o,
  output logic                            inval_done_o
);

  localparam int WAY_W = $clog2(ICACHE_N_WAY);
  localparam int PTR_W = (INVAL_Q_DEPTH > 1) ? $clog2(INVAL_Q_DEPTH) : 1;
  localparam int CNT_W = $clog2(INVAL_Q_DEPTH + 1);
  localparam logic [PTR_W-1:0]          PTR_LAST = PTR_W'(INVAL_Q_DEPTH - 1);
  localparam logic [ICACHE_IDX_WIDTH:0] FL_LAST  = {1'b0, {ICACHE_IDX_WIDTH{1'b1}}};

  typedef struct packed {
    logic [ICACHE_IDX_WIDTH-1:0] idx;
    logic [WAY_W-1:0]            way;
    logic                        all;
  } ent_t;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_INVAL, S_ACK} state_t;

  state_t                  r_state;
  logic [ICACHE_IDX_WIDTH:0] r_fl_cnt;  // one extra bit so the last set never wraps to 0
  ent_t                    r_q [INVAL_Q_DEPTH];
  logic [PTR_W-1:0]        r_wptr, r_rptr;
  logic [CNT_W-1:0]        r_count;

  logic             w_full, w_empty, w_push, w_pop, w_issue;
  logic [CNT_W-1:0] w_count_nxt;
  ent_t             w_head;
  logic [ICACHE_N_WAY-1:0] w_head_mask;

  assign w_full      = (r_count == CNT_W'(INVAL_Q_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = inval_valid_i & ~w_full;
  assign w_issue     = ~core_busy_i & ((r_state == S_FLUSH) | (r_state == S_INVAL));
  assign w_pop       = w_issue & (r_state == S_INVAL) & ~w_empty;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_head      = r_q[r_rptr];
  assign w_head_mask = w_head.all ? {ICACHE_N_WAY{1'b1}}
                                  : (ICACHE_N_WAY'(1) << w_head.way);

  assign inval_ready_o = ~w_full;
  assign we_valid_o    = w_issue;
  assign inval_o       = w_pop;
  assign inval_done_o  = w_pop;
  assign flush_ena_o   = (r_state == S_FLUSH);
  assign flush_ack_o   = (r_state == S_ACK);
  assign seq_busy_o    = (r_state != S_IDLE);
  assign addr_valid_o  = !w_issue ? '0 :
                         (r_state == S_FLUSH) ? r_fl_cnt[ICACHE_IDX_WIDTH-1:0] : w_head.idx;
  assign way_mask_o    = !w_issue ? '0 :
                         (r_state == S_FLUSH) ? {ICACHE_N_WAY{1'b1}} : w_head_mask;

  // FIFO payload storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk_i) begin
    if (w_push) r_q[r_wptr] <= '{idx: inval_idx_i, way: inval_way_i, all: inval_all_i};
  end

  // FIFO pointers and occupancy; a push and a pop in one cycle both take effect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  // Sequencer FSM: flush walk has priority over queued invalidations.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_fl_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush_req_i) begin
            r_state  <= S_FLUSH;
            r_fl_cnt <= '0;
          end else if (!w_empty) begin
            r_state <= S_INVAL;
          end
        end
        S_FLUSH: begin
          if (!core_busy_i) begin
            r_fl_cnt <= r_fl_cnt + 1'b1;
            if (r_fl_cnt == FL_LAST) r_state <= S_ACK;
          end
        end
        S_INVAL: begin
          if (w_pop && ((w_count_nxt == '0) || flush_req_i)) r_state <= S_IDLE;
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sargantana_icache_inval_sequencer.sv
// Directed bench for the icache invalidation / flush sequencer.
// Inputs change 1ns after each rising edge; outputs are checked 1ns later.
module tb_sargantana_icache_inval_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_req, flush_ack;
  logic       inval_valid, inval_ready;
  logic [5:0] inval_idx;
  logic [1:0] inval_way;
  logic       inval_all, core_busy;
  logic       seq_busy, flush_ena, inval_o, we_valid, inval_done;
  logic [5:0] addr;
  logic [3:0] mask;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sargantana_icache_inval_sequencer #(
    .ICACHE_N_WAY(4), .ICACHE_IDX_WIDTH(6), .INVAL_Q_DEPTH(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .flush_req_i(flush_req), .flush_ack_o(flush_ack),
    .inval_valid_i(inval_valid), .inval_ready_o(inval_ready),
    .inval_idx_i(inval_idx), .inval_way_i(inval_way), .inval_all_i(inval_all),
    .core_busy_i(core_busy), .seq_busy_o(seq_busy), .flush_ena_o(flush_ena),
    .inval_o(inval_o), .we_valid_o(we_valid), .addr_valid_o(addr),
    .way_mask_o(mask), .inval_done_o(inval_done)
  );

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  initial begin
    logic [5:0] exp_a;
    rst = 1'b1; flush_req = 1'b0; inval_valid = 1'b0; inval_idx = '0;
    inval_way = '0; inval_all = 1'b0; core_busy = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_outs", {flush_ack, inval_ready, seq_busy, flush_ena, inval_o, we_valid, inval_done, addr, mask},
                    {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 4'h0});
    rst = 1'b0;

    // T1: unstalled flush walk
    tk(); flush_req = 1'b1; #1;
    chk("t1_idle", {seq_busy, we_valid}, 2'b00);
    for (int w = 0; w < 64; w++) begin
      tk(); flush_req = 1'b0; #1;
      chk("t1_walk", {we_valid, flush_ena, flush_ack, addr, mask}, {1'b1, 1'b1, 1'b0, 6'(w), 4'hF});
    end
    tk(); #1;
    chk("t1_ack", {flush_ack, we_valid, seq_busy}, 3'b101);
    tk(); #1;
    chk("t1_done", {flush_ack, seq_busy, flush_ena}, 3'b000);

    // T2: walk with core stall on walk cycles 10..14
    tk(); flush_req = 1'b1; #1;
    chk("t2_idle", seq_busy, 1'b0);
    exp_a = '0;
    for (int w = 0; w < 69; w++) begin
      tk(); flush_req = 1'b0; core_busy = (w >= 10 && w <= 14); #1;
      if (w >= 10 && w <= 14)
        chk("t2_stall", {we_valid, flush_ena, addr, mask}, {1'b0, 1'b1, 6'd0, 4'h0});
      else begin
        chk("t2_walk", {we_valid, flush_ena, flush_ack, addr, mask}, {1'b1, 1'b1, 1'b0, exp_a, 4'hF});
        exp_a = exp_a + 6'd1;
      end
    end
    tk(); core_busy = 1'b0; #1;
    chk("t2_ack", {flush_ack, we_valid}, 2'b10);
    tk(); #1;
    chk("t2_done", {flush_ack, seq_busy}, 2'b00);

    // T3: two invalidations, single way then all ways
    tk(); inval_valid = 1'b1; inval_idx = 6'd5; inval_way = 2'd2; inval_all = 1'b0; #1;
    chk("t3_rdy0", inval_ready, 1'b1);
    tk(); inval_idx = 6'd9; inval_way = 2'd0; inval_all = 1'b1; #1;
    chk("t3_rdy1", {inval_ready, we_valid}, 2'b10);
    tk(); inval_valid = 1'b0; inval_all = 1'b0; #1;
    chk("t3_wr0", {we_valid, inval_o, inval_done, flush_ena, addr, mask}, {4'b1110, 6'd5, 4'b0100});
    tk(); #1;
    chk("t3_wr1", {we_valid, inval_o, inval_done, flush_ena, addr, mask}, {4'b1110, 6'd9, 4'b1111});
    tk(); #1;
    chk("t3_idle", {we_valid, inval_done, seq_busy}, 3'b000);

    // T4: backpressure with a held valid while the core is busy
    tk(); core_busy = 1'b1; inval_valid = 1'b1; inval_idx = 6'd10; inval_way = 2'd0; #1;
    chk("t4_rdy_a", inval_ready, 1'b1);
    tk(); inval_idx = 6'd11; inval_way = 2'd1; #1;
    chk("t4_rdy_b", inval_ready, 1'b1);
    tk(); inval_idx = 6'd12; inval_way = 2'd2; #1;
    chk("t4_full0", {inval_ready, we_valid, seq_busy}, 3'b001);
    tk(); #1;
    chk("t4_full1", {inval_ready, we_valid, seq_busy}, 3'b001);
    tk(); core_busy = 1'b0; #1;
    chk("t4_wr0", {inval_ready, we_valid, inval_o, addr, mask}, {3'b011, 6'd10, 4'b0001});
    tk(); #1;
    chk("t4_wr1", {inval_ready, we_valid, inval_o, addr, mask}, {3'b111, 6'd11, 4'b0010});
    tk(); inval_idx = 6'd13; inval_way = 2'd3; #1;
    chk("t4_wr2", {inval_ready, we_valid, inval_o, addr, mask}, {3'b111, 6'd12, 4'b0100});
    tk(); inval_valid = 1'b0; #1;
    chk("t4_wr3", {we_valid, inval_o, inval_done, addr, mask}, {3'b111, 6'd13, 4'b1000});
    tk(); #1;
    chk("t4_idle", {we_valid, seq_busy, inval_ready}, 3'b001);

    // T5: flush and invalidation arrive together; flush first
    tk(); flush_req = 1'b1; inval_valid = 1'b1; inval_idx = 6'd33; inval_way = 2'd1; #1;
    chk("t5_req", {inval_ready, seq_busy}, 2'b10);
    for (int w = 0; w < 64; w++) begin
      tk(); flush_req = 1'b0; inval_valid = 1'b0; #1;
      chk("t5_walk", {we_valid, flush_ena, inval_o, addr, mask}, {3'b110, 6'(w), 4'hF});
    end
    tk(); #1;
    chk("t5_ack", {flush_ack, we_valid, inval_o}, 3'b100);
    tk(); #1;
    chk("t5_gap", {we_valid, seq_busy}, 2'b00);
    tk(); #1;
    chk("t5_inv", {we_valid, inval_o, inval_done, addr, mask}, {3'b111, 6'd33, 4'b0010});
    tk(); #1;
    chk("t5_idle", {we_valid, seq_busy}, 2'b00);

    // T6: reset mid-walk with a full FIFO
    tk(); flush_req = 1'b1; #1;
    for (int w = 0; w < 30; w++) begin
      tk(); flush_req = 1'b0; inval_valid = (w == 5 || w == 6); inval_idx = 6'(40 + w); #1;
      chk("t6_walk", {we_valid, addr}, {1'b1, 6'(w)});
      if (w == 8) chk("t6_full", inval_ready, 1'b0);
    end
    tk(); inval_valid = 1'b0; rst = 1'b1; #1;
    chk("t6_rst", {flush_ack, inval_ready, seq_busy, flush_ena, inval_o, we_valid, inval_done, addr, mask},
                  {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 4'h0});
    tk(); rst = 1'b0; #1;
    for (int c = 0; c < 4; c++) begin
      tk(); #1;
      chk("t6_post", {flush_ack, seq_busy, we_valid, inval_ready}, 4'b0001);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
